// File: rtl/pe_ctx_pkg.sv
// Shared layout of the 59-bit PE context word and sequencer state encoding.
// Optional hazard checking is enabled by PESEQ_HAZARD_CHK_EN.
package pe_ctx_pkg;

  localparam int CTX_W  = 59;
  localparam int W_CIN  = 9;
  localparam int W_COUT = 9;
  localparam int W_REG  = 6;
  localparam int W_BYP  = 4;

  localparam int OFF_CIN  = 50;
  localparam int OFF_COUT = 41;
  localparam int OFF_REG1 = 35;
  localparam int OFF_REG2 = 29;
  localparam int OFF_PUTI = 23;
  localparam int OFF_PUTO = 17;
  localparam int OFF_SEND = 11;
  localparam int OFF_BYP1 = 7;
  localparam int OFF_BYP2 = 3;
  localparam int OFF_WB   = 2;
  localparam int OFF_LD   = 1;
  localparam int OFF_LDW  = 0;

  typedef struct packed {
    logic [W_CIN-1:0]  control_in;
    logic [W_COUT-1:0] control_out;
    logic [W_REG-1:0]  reg_1;
    logic [W_REG-1:0]  reg_2;
    logic [W_REG-1:0]  put_in;
    logic [W_REG-1:0]  put_out;
    logic [W_REG-1:0]  send;
    logic [W_BYP-1:0]  pe2fu_1;
    logic [W_BYP-1:0]  pe2fu_2;
    logic              write_back;
    logic              ld;
    logic              ld_write;
  } ctx_t;

  // ld=1 with ld_write=0 keeps the PE from loading or writing anything
  localparam logic [CTX_W-1:0] NOP_WORD = {{(CTX_W-2){1'b0}}, 2'b10};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } seq_state_e;

  function automatic ctx_t ctx_unpack(input logic [CTX_W-1:0] w);
    ctx_t c;
    c.control_in  = w[OFF_CIN  +: W_CIN];
    c.control_out = w[OFF_COUT +: W_COUT];
    c.reg_1       = w[OFF_REG1 +: W_REG];
    c.reg_2       = w[OFF_REG2 +: W_REG];
    c.put_in      = w[OFF_PUTI +: W_REG];
    c.put_out     = w[OFF_PUTO +: W_REG];
    c.send        = w[OFF_SEND +: W_REG];
    c.pe2fu_1     = w[OFF_BYP1 +: W_BYP];
    c.pe2fu_2     = w[OFF_BYP2 +: W_BYP];
    c.write_back  = w[OFF_WB];
    c.ld          = w[OFF_LD];
    c.ld_write    = w[OFF_LDW];
    return c;
  endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context word store: one synchronous write port, one combinational read.
// Contents are intentionally not reset.
module pe_ctx_mem
  import pe_ctx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [CTX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [CTX_W-1:0] rdata
);

  logic [CTX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Replays a loop of context words into one CGRA PE register/FU tile.
// Define PESEQ_HAZARD_CHK_EN to add write-back/load conflict suppression.
module pe_ctx_sequencer
  import pe_ctx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int ITW   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CTX_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic [AW-1:0]    last_pc,
  input  logic [ITW-1:0]   iter_cnt,
  input  logic             stall,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             ctrl_valid,
  output logic [8:0]       control_in,
  output logic [8:0]       control_out,
  output logic [5:0]       control_reg_1,
  output logic [5:0]       control_reg_2,
  output logic [5:0]       control_put_in,
  output logic [5:0]       control_put_out,
  output logic [5:0]       control_send,
  output logic [3:0]       control_pe2fu_1,
  output logic [3:0]       control_pe2fu_2,
  output logic             write_back,
  output logic             ld,
  output logic             ld_write
`ifdef PESEQ_HAZARD_CHK_EN
  ,
  output logic             hazard
`endif
);

  localparam ctx_t NOP_CTX = ctx_t'(NOP_WORD);

  seq_state_e       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    last_q, last_d;
  logic [ITW-1:0]   it_q, it_d;
  ctx_t             out_q, out_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic [CTX_W-1:0] fetch_raw;
  ctx_t             fetch;
  ctx_t             issue;
  logic             mem_we;

  assign mem_we = RST_N && cfg_we && !abort && (state_q == S_IDLE);

  pe_ctx_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (pc_q),
    .rdata (fetch_raw)
  );

  assign fetch = ctx_unpack(fetch_raw);

`ifdef PESEQ_HAZARD_CHK_EN
  logic haz_q, haz_d;
  logic conflict;

  // a neighbour load into the same register beats FU write-back
  assign conflict = fetch.write_back
                 && (fetch.put_in == fetch.put_out)
                 && (!fetch.ld || fetch.ld_write);

  always_comb begin
    issue = fetch;
    if (conflict) issue.write_back = 1'b0;
  end

  assign hazard = haz_q;
`else
  assign issue = fetch;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    it_d    = it_q;
    out_d   = NOP_CTX;
    vld_d   = 1'b0;
    done_d  = 1'b0;
`ifdef PESEQ_HAZARD_CHK_EN
    haz_d   = 1'b0;
`endif
    if (abort) begin
      state_d = S_IDLE;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            pc_d    = '0;
            last_d  = last_pc;
            it_d    = (iter_cnt == '0) ? ITW'(1) : iter_cnt;
          end
        end
        S_RUN: begin
          if (!stall) begin
            out_d = issue;
            vld_d = 1'b1;
`ifdef PESEQ_HAZARD_CHK_EN
            haz_d = conflict;
`endif
            if (pc_q == last_q) begin
              pc_d = '0;
              it_d = it_q - ITW'(1);
              if (it_q == ITW'(1)) state_d = S_DRAIN;
            end else begin
              pc_d = pc_q + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      it_q    <= '0;
      out_q   <= NOP_CTX;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PESEQ_HAZARD_CHK_EN
      haz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      it_q    <= it_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
`ifdef PESEQ_HAZARD_CHK_EN
      haz_q   <= haz_d;
`endif
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign ctrl_valid      = vld_q;
  assign control_in      = out_q.control_in;
  assign control_out     = out_q.control_out;
  assign control_reg_1   = out_q.reg_1;
  assign control_reg_2   = out_q.reg_2;
  assign control_put_in  = out_q.put_in;
  assign control_put_out = out_q.put_out;
  assign control_send    = out_q.send;
  assign control_pe2fu_1 = out_q.pe2fu_1;
  assign control_pe2fu_2 = out_q.pe2fu_2;
  assign write_back      = out_q.write_back;
  assign ld              = out_q.ld;
  assign ld_write        = out_q.ld_write;

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Randomised and directed bench for pe_ctx_sequencer against a
// queue-based model of the issued word stream.
module tb_pe_ctx_sequencer;

  localparam int AW  = 4;
  localparam int ITW = 8;
  localparam logic [58:0] NOP = 59'h2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [58:0] cfg_wdata = '0;
  logic        start = 1'b0;
  logic [3:0]  last_pc = '0;
  logic [7:0]  iter_cnt = '0;
  logic        stall = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, ctrl_valid;
  logic [8:0]  control_in, control_out;
  logic [5:0]  control_reg_1, control_reg_2;
  logic [5:0]  control_put_in, control_put_out, control_send;
  logic [3:0]  control_pe2fu_1, control_pe2fu_2;
  logic        write_back, ld, ld_write;
`ifdef PESEQ_HAZARD_CHK_EN
  logic        hazard;
`endif

  pe_ctx_sequencer #(.DEPTH(16), .AW(AW), .ITW(ITW)) dut (
`ifdef PESEQ_HAZARD_CHK_EN
    .hazard          (hazard),
`endif
    .CLK             (CLK),
    .RST_N           (RST_N),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .start           (start),
    .last_pc         (last_pc),
    .iter_cnt        (iter_cnt),
    .stall           (stall),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .ctrl_valid      (ctrl_valid),
    .control_in      (control_in),
    .control_out     (control_out),
    .control_reg_1   (control_reg_1),
    .control_reg_2   (control_reg_2),
    .control_put_in  (control_put_in),
    .control_put_out (control_put_out),
    .control_send    (control_send),
    .control_pe2fu_1 (control_pe2fu_1),
    .control_pe2fu_2 (control_pe2fu_2),
    .write_back      (write_back),
    .ld              (ld),
    .ld_write        (ld_write)
  );

  always #5 CLK = ~CLK;

  logic [58:0] dut_word;
  assign dut_word = {control_in, control_out, control_reg_1,
                     control_reg_2, control_put_in, control_put_out,
                     control_send, control_pe2fu_1, control_pe2fu_2,
                     write_back, ld, ld_write};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---- reference model: words queued at start, popped per unstalled cycle
  logic [58:0] m_mem [16];
  logic [58:0] m_q [$];
  bit          m_active = 0;
  bit          m_drain = 0;
  bit          armed = 0;
  int          cyc = 0;
  logic [58:0] exp_word = NOP;
  bit          exp_valid = 0, exp_done = 0, exp_busy = 0, exp_haz = 0;

  task automatic model_step();
    logic [58:0] w;
    int n;
    cyc++;
    armed = 1;
    exp_word = NOP;
    exp_valid = 0;
    exp_done = 0;
    exp_haz = 0;
    if (!RST_N || abort) begin
      m_active = 0;
      m_drain = 0;
      m_q.delete();
    end else if (m_drain) begin
      exp_done = 1;
      m_drain = 0;
      m_active = 0;
    end else if (m_active) begin
      if (!stall) begin
        w = m_q.pop_front();
`ifdef PESEQ_HAZARD_CHK_EN
        if (w[2] && w[28:23] == w[22:17] && (!w[1] || w[0])) begin
          w[2] = 1'b0;
          exp_haz = 1;
        end
`endif
        exp_word = w;
        exp_valid = 1;
        if (m_q.size() == 0) m_drain = 1;
      end
    end else begin
      if (cfg_we) m_mem[cfg_addr] = cfg_wdata;
      if (start) begin
        n = (iter_cnt == 0) ? 1 : int'(iter_cnt);
        for (int i = 0; i < n; i++)
          for (int p = 0; p <= int'(last_pc); p++)
            m_q.push_back(m_mem[p]);
        m_active = 1;
      end
    end
    exp_busy = m_active;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // ---- compare + trace capture, away from the active edge
  logic [58:0] seen [$];
  int first_v = -1, last_v = -1, done_cnt = 0, done_c = -1;

  initial forever begin
    @(negedge CLK);
    if (armed) begin
      chk("word", {5'b0, dut_word}, {5'b0, exp_word});
      chk("ctrl_valid", {63'b0, ctrl_valid}, {63'b0, exp_valid});
      chk("busy", {63'b0, busy}, {63'b0, exp_busy});
      chk("done", {63'b0, done}, {63'b0, exp_done});
`ifdef PESEQ_HAZARD_CHK_EN
      chk("hazard", {63'b0, hazard}, {63'b0, exp_haz});
`endif
      if (ctrl_valid === 1'b1) begin
        seen.push_back(dut_word);
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_c = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_trace();
    seen.delete();
    first_v = -1;
    last_v = -1;
    done_cnt = 0;
    done_c = -1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [58:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] lp, input logic [7:0] it);
    start = 1'b1;
    last_pc = lp;
    iter_cnt = it;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_seq(input string nm, input logic [58:0] e [$]);
    logic [63:0] act;
    chk({nm, "_len"}, 64'(seen.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      act = (i < seen.size()) ? {5'b0, seen[i]} : '1;
      chk(nm, act, {5'b0, e[i]});
    end
  endtask

  localparam logic [58:0] WA = {9'h1A5, 9'h0F3, 6'd1, 6'd2, 6'd3,
                                6'd4, 6'd5, 4'h6, 4'h7, 3'b100};
  localparam logic [58:0] WB = {9'h003, 9'h1FF, 6'd10, 6'd11, 6'd12,
                                6'd13, 6'd14, 4'h1, 4'h2, 3'b110};
  localparam logic [58:0] WC = {9'h100, 9'h001, 6'd20, 6'd21, 6'd22,
                                6'd23, 6'd24, 4'h3, 4'h4, 3'b011};
  localparam logic [58:0] WH = {9'h0, 9'h0, 6'd0, 6'd0, 6'd5,
                                6'd5, 6'd0, 4'h0, 4'h0, 3'b100};

  initial begin
    logic [58:0] e [$];
    logic [58:0] hexp;
    // reset
    tick();
    tick();
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_valid", {63'b0, ctrl_valid}, 64'd0);
    chk("rst_ld", {63'b0, ld}, 64'd1);
    chk("rst_word", {5'b0, dut_word}, {5'b0, NOP});
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < 16; i++)
      cfg_write(4'(i), {$urandom, $urandom});
    cfg_write(4'd0, WA);
    cfg_write(4'd1, WB);
    cfg_write(4'd2, WC);

    // A,B,C twice
    clear_trace();
    go(4'd2, 8'd2);
    chk("lat_e0_valid", {63'b0, ctrl_valid}, 64'd0);
    tick();
    chk("lat_e1_word", {5'b0, dut_word}, {5'b0, WA});
    repeat (10) tick();
    e = '{WA, WB, WC, WA, WB, WC};
    expect_seq("run2", e);
    chk("run2_done_cnt", 64'(done_cnt), 64'd1);
    chk("run2_done_pos", 64'(done_c), 64'(last_v + 1));

    // three stall bubbles during the first B
    clear_trace();
    go(4'd2, 8'd2);
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (12) tick();
    expect_seq("stall", e);
    chk("stall_span", 64'(last_v - first_v + 1), 64'd9);
    chk("stall_done_cnt", 64'(done_cnt), 64'd1);

    // abort on the second A; write during RUN must be dropped
    clear_trace();
    go(4'd2, 8'd2);
    cfg_we = 1'b1;
    cfg_addr = 4'd1;
    cfg_wdata = 59'h7FF_FFFF_FFFF_FFF0;
    tick();
    cfg_we = 1'b0;
    repeat (3) tick();
    chk("abort_pre_word", {5'b0, dut_word}, {5'b0, WA});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_word", {5'b0, dut_word}, {5'b0, NOP});
    repeat (4) tick();
    e = '{WA, WB, WC, WA};
    expect_seq("abort", e);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    clear_trace();
    go(4'd2, 8'd1);
    repeat (6) tick();
    e = '{WA, WB, WC};
    expect_seq("rerun", e);
    chk("rerun_done_cnt", 64'(done_cnt), 64'd1);

    // iter_cnt=0 acts as a single pass
    clear_trace();
    go(4'd0, 8'd0);
    repeat (4) tick();
    e = '{WA};
    expect_seq("iter0", e);
    chk("iter0_done_cnt", 64'(done_cnt), 64'd1);

    // write-back vs load conflict word
    cfg_write(4'd0, WH);
    go(4'd0, 8'd1);
    tick();
`ifdef PESEQ_HAZARD_CHK_EN
    hexp = WH & ~59'h4;
    chk("haz_flag", {63'b0, hazard}, 64'd1);
`else
    hexp = WH;
`endif
    chk("haz_word", {5'b0, dut_word}, {5'b0, hexp});
    tick();
`ifdef PESEQ_HAZARD_CHK_EN
    chk("haz_pulse_end", {63'b0, hazard}, 64'd0);
`endif
    repeat (3) tick();

    // randomised traffic; the model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      RST_N     = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 9) == 0);
      last_pc   = 4'($urandom_range(0, 15));
      iter_cnt  = 8'($urandom_range(0, 3));
      stall     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 49) == 0);
      cfg_we    = ($urandom_range(0, 2) == 0);
      cfg_addr  = 4'($urandom_range(0, 15));
      cfg_wdata = {$urandom, $urandom};
      tick();
    end
    RST_N = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    cfg_we = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
